// File: rtl/accum_alu.sv
// Accumulating ALU: one-cycle LOAD/ADD/SUB/AND/OR/XOR/CLEAR and an iterative shift-add MUL with ready back-pressure.
// Optional feature macro ACCUM_SAT_EN: clamp ADD/MUL overflow to all ones and SUB borrow to zero.
module accum_alu #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             capture,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d_in,
    output logic             ready,
    output logic [WIDTH:0]   result,
    output logic             valid,
    output logic             ovf
);

    localparam int AW = WIDTH + 1;
    localparam int PW = 2 * WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_SUB   = 3'b010;
    localparam logic [2:0] OP_AND   = 3'b011;
    localparam logic [2:0] OP_OR    = 3'b100;
    localparam logic [2:0] OP_XOR   = 3'b101;
    localparam logic [2:0] OP_MUL   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_MUL_RUN = 1'b1
    } state_t;

    state_t           r_state;
    logic [AW-1:0]    r_acc;
    logic             r_valid;
    logic             r_ovf;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_mplier;
    logic [AW-1:0]    r_mcand;
    logic [PW-1:0]    r_prod;

    state_t           w_state_nxt;
    logic [AW-1:0]    w_acc_nxt;
    logic             w_valid_nxt;
    logic             w_ovf_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] w_mplier_nxt;
    logic [AW-1:0]    w_mcand_nxt;
    logic [PW-1:0]    w_prod_nxt;

    logic [AW-1:0]    w_din_ext;
    logic [AW:0]      w_sum;
    logic [AW:0]      w_diff;
    logic [PW-1:0]    w_partial;
    logic [PW-1:0]    w_prod_fin;
    logic             w_mul_ovf;
    logic             w_last;

    assign w_din_ext  = {1'b0, d_in};
    assign w_sum      = {1'b0, r_acc} + {1'b0, w_din_ext};
    assign w_diff     = {1'b0, r_acc} - {1'b0, w_din_ext};
    // Multiplicand was latched from the accumulator at capture; each step adds it at weight 2^r_cnt.
    assign w_partial  = {{(PW - AW){1'b0}}, r_mcand} << r_cnt;
    assign w_prod_fin = r_mplier[0] ? (r_prod + w_partial) : r_prod;
    assign w_mul_ovf  = |w_prod_fin[PW-1:AW];
    assign w_last     = (r_cnt == CW'(WIDTH - 1));

    assign ready  = (r_state == S_IDLE);
    assign result = r_acc;
    assign valid  = r_valid;
    assign ovf    = r_ovf;

    // Next-state, operation execution and multiply iteration.
    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_valid_nxt  = 1'b0;
        w_ovf_nxt    = r_ovf;
        w_cnt_nxt    = r_cnt;
        w_mplier_nxt = r_mplier;
        w_mcand_nxt  = r_mcand;
        w_prod_nxt   = r_prod;
        case (r_state)
            S_IDLE: begin
                if (capture) begin
                    if (op == OP_MUL) begin
                        w_state_nxt  = S_MUL_RUN;
                        w_mcand_nxt  = r_acc;
                        w_mplier_nxt = d_in;
                        w_prod_nxt   = {PW{1'b0}};
                        w_cnt_nxt    = {CW{1'b0}};
                    end else begin
                        w_valid_nxt = 1'b1;
                        w_ovf_nxt   = 1'b0;
                        case (op)
                            OP_LOAD:  w_acc_nxt = w_din_ext;
                            OP_ADD: begin
                                w_ovf_nxt = w_sum[AW];
`ifdef ACCUM_SAT_EN
                                w_acc_nxt = w_sum[AW] ? {AW{1'b1}} : w_sum[AW-1:0];
`else
                                w_acc_nxt = w_sum[AW-1:0];
`endif
                            end
                            OP_SUB: begin
                                w_ovf_nxt = w_diff[AW];
`ifdef ACCUM_SAT_EN
                                w_acc_nxt = w_diff[AW] ? {AW{1'b0}} : w_diff[AW-1:0];
`else
                                w_acc_nxt = w_diff[AW-1:0];
`endif
                            end
                            OP_AND:   w_acc_nxt = r_acc & w_din_ext;
                            OP_OR:    w_acc_nxt = r_acc | w_din_ext;
                            OP_XOR:   w_acc_nxt = r_acc ^ w_din_ext;
                            OP_CLEAR: w_acc_nxt = {AW{1'b0}};
                            default:  w_acc_nxt = r_acc;
                        endcase
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MUL_RUN: begin
                w_prod_nxt   = w_prod_fin;
                w_mplier_nxt = r_mplier >> 1;
                w_cnt_nxt    = r_cnt + CW'(1);
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                    w_valid_nxt = 1'b1;
                    w_ovf_nxt   = w_mul_ovf;
                    w_cnt_nxt   = {CW{1'b0}};
`ifdef ACCUM_SAT_EN
                    w_acc_nxt   = w_mul_ovf ? {AW{1'b1}} : w_prod_fin[AW-1:0];
`else
                    w_acc_nxt   = w_prod_fin[AW-1:0];
`endif
                end else begin
                    w_state_nxt = S_MUL_RUN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; synchronous reset wins over any capture.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_acc    <= {AW{1'b0}};
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
            r_cnt    <= {CW{1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_mcand  <= {AW{1'b0}};
            r_prod   <= {PW{1'b0}};
        end else begin
            r_state  <= w_state_nxt;
            r_acc    <= w_acc_nxt;
            r_valid  <= w_valid_nxt;
            r_ovf    <= w_ovf_nxt;
            r_cnt    <= w_cnt_nxt;
            r_mplier <= w_mplier_nxt;
            r_mcand  <= w_mcand_nxt;
            r_prod   <= w_prod_nxt;
        end
    end

endmodule

// File: tb/tb_accum_alu.sv
// Self-checking bench for accum_alu (WIDTH=4): directed scenarios plus random ops against an arithmetic model.
module tb_accum_alu;

    localparam int W   = 4;
    localparam int MOD = 1 << (W + 1);

    logic         clock = 1'b0;
    logic         rst;
    logic         capture;
    logic [2:0]   op;
    logic [W-1:0] d_in;
    logic         ready;
    logic [W:0]   result;
    logic         valid;
    logic         ovf;

    int total = 0;
    int bad   = 0;
    int m_acc = 0;
    int m_ovf = 0;

    accum_alu #(.WIDTH(W)) dut (
        .clock   (clock),
        .rst     (rst),
        .capture (capture),
        .op      (op),
        .d_in    (d_in),
        .ready   (ready),
        .result  (result),
        .valid   (valid),
        .ovf     (ovf)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the accumulator value.
    task automatic model_apply(input int o, input int d);
        int p;
        case (o)
            0: begin m_acc = d; m_ovf = 0; end
            1: begin
                p = m_acc + d;
                m_ovf = (p >= MOD) ? 1 : 0;
`ifdef ACCUM_SAT_EN
                m_acc = (m_ovf == 1) ? MOD - 1 : p;
`else
                m_acc = p % MOD;
`endif
            end
            2: begin
                m_ovf = (d > m_acc) ? 1 : 0;
`ifdef ACCUM_SAT_EN
                m_acc = (m_ovf == 1) ? 0 : m_acc - d;
`else
                m_acc = (m_acc - d + MOD) % MOD;
`endif
            end
            3: begin m_acc = m_acc & d; m_ovf = 0; end
            4: begin m_acc = m_acc | d; m_ovf = 0; end
            5: begin m_acc = m_acc ^ d; m_ovf = 0; end
            6: begin
                p = m_acc * d;
                m_ovf = (p >= MOD) ? 1 : 0;
`ifdef ACCUM_SAT_EN
                m_acc = (m_ovf == 1) ? MOD - 1 : p;
`else
                m_acc = p % MOD;
`endif
            end
            default: begin m_acc = 0; m_ovf = 0; end
        endcase
    endtask

    // Called at a negedge with ready=1; returns at the negedge after completion.
    task automatic run_op(input int o, input int d, input bit poke);
        int prev_acc;
        int prev_ovf;
        int v;
        prev_acc = m_acc;
        prev_ovf = m_ovf;
        v = o;
        op = v[2:0];
        v = d;
        d_in = v[W-1:0];
        capture = 1'b1;
        model_apply(o, d);
        @(negedge clock);
        capture = 1'b0;
        if (o == 6) begin
            for (int i = 0; i < W; i++) begin
                check("mul_busy_ready", ready, 0);
                check("mul_busy_valid", valid, 0);
                check("mul_busy_result", result, prev_acc);
                check("mul_busy_ovf", ovf, prev_ovf);
                if (poke) begin
                    capture = 1'b1;
                    op = 3'b001;
                    d_in = 4'($urandom_range(0, 15));
                end
                @(negedge clock);
                capture = 1'b0;
            end
        end
        check("done_valid", valid, 1);
        check("done_result", result, m_acc);
        check("done_ovf", ovf, m_ovf);
        check("done_ready", ready, 1);
    endtask

    task automatic idle_cycle();
        capture = 1'b0;
        @(negedge clock);
        check("idle_valid", valid, 0);
        check("idle_result", result, m_acc);
        check("idle_ovf", ovf, m_ovf);
    endtask

    initial begin
        rst = 1'b1;
        capture = 1'b0;
        op = 3'b000;
        d_in = 4'd0;
        @(negedge clock);
        check("rst_result", result, 0);
        check("rst_valid", valid, 0);
        check("rst_ovf", ovf, 0);
        check("rst_ready", ready, 1);
        @(negedge clock);
        rst = 1'b0;
        m_acc = 0;
        m_ovf = 0;

        run_op(0, 9, 0);
        run_op(1, 7, 0);
        run_op(1, 15, 0);
        run_op(1, 1, 0);
        idle_cycle();

        run_op(0, 3, 0);
        run_op(2, 5, 0);
        run_op(5, 15, 0);
        run_op(7, 0, 0);
        idle_cycle();

        run_op(0, 7, 0);
        run_op(6, 13, 1);
        idle_cycle();

        run_op(0, 6, 0);
        run_op(6, 5, 0);
        run_op(1, 1, 0);
        idle_cycle();

        // Multiply aborted by reset at iteration 2, with a capture on the reset edge.
        run_op(0, 15, 0);
        run_op(1, 15, 0);
        run_op(1, 15, 0);
        capture = 1'b1;
        op = 3'b110;
        d_in = 4'd3;
        @(negedge clock);
        capture = 1'b0;
        @(negedge clock);
        rst = 1'b1;
        capture = 1'b1;
        op = 3'b000;
        d_in = 4'd9;
        @(negedge clock);
        rst = 1'b0;
        capture = 1'b0;
        m_acc = 0;
        m_ovf = 0;
        check("abort_valid", valid, 0);
        check("abort_result", result, 0);
        check("abort_ready", ready, 1);
        check("abort_ovf", ovf, 0);
        for (int i = 0; i <= W; i++) begin
            idle_cycle();
        end

        for (int n = 0; n < 300; n++) begin
            run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 4) == 0) begin
                idle_cycle();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
